// File: rtl/sobel_edge_gen.sv
// Sobel edge engine: builds a 1-bit edge map from an external 8-bit image ROM,
// then scans that map out 4x upscaled as 12-bit colour for the VGA DAC.
module sobel_edge_gen #(
    parameter int          IMG_W    = 160,
    parameter int          IMG_H    = 120,
    parameter int          THRESH   = 100,
    parameter logic [11:0] EDGE_RGB = 12'hFFF,
    parameter logic [11:0] BG_RGB   = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    output logic        busy,
    output logic        done,
    output logic [11:0] rgb,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LAST  = 3'd2;
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    localparam int          NPIX     = IMG_W * IMG_H;
    localparam int          AW       = $clog2(NPIX);
    localparam logic [7:0]  COL_MAX  = 8'(IMG_W - 1);
    localparam logic [7:0]  ROW_MAX  = 8'(IMG_H - 1);
    localparam logic [14:0] ROW_STEP = 15'(IMG_W - 2);

    // Constant multiply; for IMG_W=160 this reduces to (r<<7)+(r<<5).
    function automatic logic [14:0] pix_addr(input logic [7:0] r, input logic [7:0] c);
        return 15'(r * IMG_W) + {7'd0, c};
    endfunction

    function automatic logic is_border(input logic [7:0] r, input logic [7:0] c);
        return (r == 8'd0) || (r == ROW_MAX) || (c == 8'd0) || (c == COL_MAX);
    endfunction

    logic [2:0]  state_q, state_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  col_q, col_d;
    logic [3:0]  k_q, k_d;
    logic [14:0] rom_addr_q, rom_addr_d;
    logic [10:0] mag_q, mag_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  p_q [0:8];
    logic        von_q;
    logic [11:0] rgb_q;
    logic        rd_bit_q;
    logic        edge_mem [0:NPIX-1];

    logic        last_col;
    logic [7:0]  nrow, ncol;
    logic        wr_en, wr_bit;
    logic [14:0] wr_addr, rd_addr;
    logic        cap_en;
    logic [3:0]  cap_idx;
    logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg, gx, gy, ax, ay, mag_c;
    logic        unused_disp_bits;

    assign last_col = (col_q == COL_MAX);
    assign ncol     = last_col ? 8'd0 : col_q + 8'd1;
    assign nrow     = last_col ? row_q + 8'd1 : row_q;

    // Window step k's data arrives one clk after its address, so p[k-1] lands during step k.
    assign cap_en  = ((state_q == S_FETCH) && (k_q != 4'd0)) || (state_q == S_LAST);
    assign cap_idx = (state_q == S_LAST) ? 4'd8 : k_q - 4'd1;

    assign gx_pos = 11'(p_q[2]) + 11'({p_q[5], 1'b0}) + 11'(p_q[8]);
    assign gx_neg = 11'(p_q[0]) + 11'({p_q[3], 1'b0}) + 11'(p_q[6]);
    assign gy_pos = 11'(p_q[6]) + 11'({p_q[7], 1'b0}) + 11'(p_q[8]);
    assign gy_neg = 11'(p_q[0]) + 11'({p_q[1], 1'b0}) + 11'(p_q[2]);
    assign gx     = gx_pos - gx_neg;
    assign gy     = gy_pos - gy_neg;
    assign ax     = gx[10] ? (11'd0 - gx) : gx;
    assign ay     = gy[10] ? (11'd0 - gy) : gy;
    assign mag_c  = ax + ay;

    assign wr_addr = pix_addr(row_q, col_q);
    assign wr_bit  = !is_border(row_q, col_q) && (mag_q >= 11'(THRESH));
    assign rd_addr = 15'(y[9:2] * IMG_W) + {7'd0, x[9:2]};
    assign unused_disp_bits = ^{x[1:0], y[1:0]};

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        k_d        = k_q;
        rom_addr_d = rom_addr_q;
        mag_d      = mag_q;
        busy_d     = busy_q;
        done_d     = done_q;
        wr_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    row_d   = 8'd0;
                    col_d   = 8'd0;
                    k_d     = 4'd0;
                    state_d = S_WRITE;  // pixel (0,0) is always a border pixel
                end
            end
            S_FETCH: begin
                if (k_q == 4'd8) begin
                    state_d = S_LAST;
                end else begin
                    k_d        = k_q + 4'd1;
                    rom_addr_d = rom_addr_q + (((k_q == 4'd2) || (k_q == 4'd5)) ? ROW_STEP : 15'd1);
                end
            end
            S_LAST: state_d = S_CALC;
            S_CALC: begin
                mag_d   = mag_c;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                wr_en = 1'b1;
                if ((row_q == ROW_MAX) && last_col) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    row_d = nrow;
                    col_d = ncol;
                    if (is_border(nrow, ncol)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d    = S_FETCH;
                        k_d        = 4'd0;
                        rom_addr_d = pix_addr(nrow - 8'd1, ncol - 8'd1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            row_q      <= 8'd0;
            col_q      <= 8'd0;
            k_q        <= 4'd0;
            rom_addr_q <= 15'd0;
            mag_q      <= 11'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            von_q      <= 1'b0;
            rgb_q      <= 12'h000;
            for (int i = 0; i < 9; i++) p_q[i] <= 8'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            k_q        <= k_d;
            rom_addr_q <= rom_addr_d;
            mag_q      <= mag_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            if (cap_en) p_q[cap_idx] <= rom_data;
            von_q <= video_on;
            if (von_q && done_q) rgb_q <= rd_bit_q ? EDGE_RGB : BG_RGB;
            else                 rgb_q <= 12'h000;
        end
    end

    // Dual-port edge map: engine writes, display reads; not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en) edge_mem[wr_addr[AW-1:0]] <= wr_bit;
        rd_bit_q <= (rd_addr < 15'(NPIX)) ? edge_mem[rd_addr[AW-1:0]] : 1'b0;
    end

    assign rom_addr  = rom_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rgb       = rgb_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sobel_edge_gen.sv
// Bench for sobel_edge_gen on a reduced 16x12 image: random display traffic
// checked every cycle against an image-level Sobel model, plus frame timing.
module tb_sobel_edge_gen;

    localparam int W          = 16;
    localparam int H          = 12;
    localparam int THR        = 100;
    localparam int N_INT      = (W - 2) * (H - 2);
    localparam int FRAME_CLKS = N_INT * 12 + (W * H - N_INT);

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        busy;
    logic        done;
    logic [11:0] rgb;
    logic [2:0]  dbg_state;

    logic [7:0]  img [0:W*H-1];
    bit          cur_map [0:W*H-1];
    int          checks = 0;
    int          failures = 0;
    logic [12:0] exp_q[$];
    logic [12:0] e;
    logic        prev_done = 1'b0;

    sobel_edge_gen #(.IMG_W(W), .IMG_H(H), .THRESH(THR)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .x        (x),
        .y        (y),
        .video_on (video_on),
        .busy     (busy),
        .done     (done),
        .rgb      (rgb),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / external ROM ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (int'(rom_addr) < W * H) rom_data <= img[int'(rom_addr)];
        else                        rom_data <= 8'h00;
    end

    // ---------------- model ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pix(input int r, input int c);
        return int'(img[r * W + c]);
    endfunction

    function automatic int mag_at(input int r, input int c);
        int gx, gy;
        gx = (pix(r-1, c+1) + 2 * pix(r, c+1) + pix(r+1, c+1))
           - (pix(r-1, c-1) + 2 * pix(r, c-1) + pix(r+1, c-1));
        gy = (pix(r+1, c-1) + 2 * pix(r+1, c) + pix(r+1, c+1))
           - (pix(r-1, c-1) + 2 * pix(r-1, c) + pix(r-1, c+1));
        return (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    endfunction

    function automatic void build_map();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                cur_map[r * W + c] = (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 1'b0
                                   : (mag_at(r, c) >= THR);
    endfunction

    function automatic logic [11:0] exp_rgb(input logic [9:0] xx, input logic [9:0] yy,
                                            input logic von, input logic dn);
        if (!von || !dn) return 12'h000;
        return cur_map[int'(yy >> 2) * W + int'(xx >> 2)] ? 12'hFFF : 12'h000;
    endfunction

    // ---------------- scoreboard: rgb reflects inputs two cycles back ----------------
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            check("rgb_in_reset", rgb, 0);
        end else begin
            if (exp_q.size() == 2) begin
                e = exp_q.pop_front();
                if (e[12] == prev_done) check("rgb_pipe", rgb, e[11:0]);
            end
            exp_q.push_back({done, exp_rgb(x, y, video_on, done)});
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_image(input int kind, input int v);
        int val;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0: val = v;
                    1: val = (c < W / 2) ? 0 : v;
                    2: val = (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 255 : 0;
                    default: val = $urandom_range(0, 255);
                endcase
                img[r * W + c] = 8'(val);
            end
    endtask

    task automatic drive_rand();
        if ($urandom_range(0, 7) == 0) begin
            video_on = 1'b0;
            x = 10'($urandom_range(0, 799));
            y = 10'($urandom_range(0, 524));
        end else begin
            video_on = 1'b1;
            x = 10'($urandom_range(0, W * 4 - 1));
            y = 10'($urandom_range(0, H * 4 - 1));
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            drive_rand();
        end
    endtask

    task automatic sweep();
        for (int yy = 0; yy < H * 4; yy++)
            for (int xx = 0; xx < W * 4; xx++) begin
                @(posedge clk); #1;
                x = 10'(xx); y = 10'(yy); video_on = 1'b1;
            end
    endtask

    task automatic run_frame(input string tag, input int restart_at);
        int n, busy_low;
        @(posedge clk); #1;
        start = 1'b1;
        drive_rand();
        @(posedge clk); #1;
        start = 1'b0;
        build_map();
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_done_clear"}, done, 0);
        n = 0;
        busy_low = 0;
        while (!done && n < FRAME_CLKS + 200) begin
            if (!busy) busy_low++;
            start = (n == restart_at);
            drive_rand();
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_frame_clks"}, n, FRAME_CLKS);
        check({tag, "_busy_gaps"}, busy_low, 0);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_done_rise"}, done, 1);
    endtask

    task automatic probe(input string name, input int xx, input int yy,
                         input logic von, input logic [11:0] want);
        @(posedge clk); #1;
        x = 10'(xx); y = 10'(yy); video_on = von;
        repeat (2) @(posedge clk);
        #1;
        check(name, rgb, want);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; start = 1'b0; x = '0; y = '0; video_on = 1'b0;
        for (int i = 0; i < W * H; i++) img[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rgb", rgb, 0);
        check("rst_rom_addr", rom_addr, 0);
        reset = 1'b0;
        idle_cycles(5);

        load_image(0, 128);
        run_frame("uniform", -1);
        idle_cycles(300);

        load_image(1, 255);
        run_frame("step", -1);
        check("model_step_left", int'(cur_map[3 * W + W / 2 - 1]), 1);
        check("model_step_right", int'(cur_map[3 * W + W / 2]), 1);
        check("model_step_flat", int'(cur_map[3 * W + W / 2 - 2]), 0);
        check("model_step_top", int'(cur_map[W / 2 - 1]), 0);
        sweep();
        probe("step_edge", (W / 2) * 4 + 1, 8, 1'b1, 12'hFFF);
        probe("step_flat", 4, 8, 1'b1, 12'h000);
        probe("step_border_row", (W / 2) * 4, 1, 1'b1, 12'h000);

        load_image(1, 25);
        check("model_mag25", mag_at(4, W / 2 - 1), 100);
        run_frame("v25", -1);
        probe("v25_edge", (W / 2 - 1) * 4 + 2, 20, 1'b1, 12'hFFF);
        idle_cycles(200);

        load_image(1, 24);
        check("model_mag24", mag_at(4, W / 2), 96);
        run_frame("v24", -1);
        probe("v24_no_edge", (W / 2 - 1) * 4 + 2, 20, 1'b1, 12'h000);
        idle_cycles(200);

        load_image(2, 0);
        run_frame("ring", -1);
        probe("ring_border", 0, 20, 1'b1, 12'h000);
        probe("ring_corner_interior", 5, 5, 1'b1, 12'hFFF);
        idle_cycles(300);

        load_image(3, 0);
        run_frame("rand", -1);
        idle_cycles(400);

        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycles(1000);
        check("abort_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rgb", rgb, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        run_frame("restart", 50);
        idle_cycles(300);

        load_image(1, 255);
        run_frame("step2", -1);
        @(posedge clk); #1;
        x = 10'((W / 2) * 4); y = 10'd20; video_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("von0_rgb", rgb, 0);
        video_on = 1'b1;
        @(posedge clk); #1;
        check("von1_one_clk", rgb, 0);
        @(posedge clk); #1;
        check("von1_two_clk", rgb, 12'hFFF);
        idle_cycles(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/sobel_edge_gen.md
# sobel_edge_gen

Frame-level Sobel edge engine and pixel generator for the VGA output path. On a start pulse it reads a 160x120 8-bit grayscale image from an external synchronous ROM, computes a thresholded Sobel magnitude per pixel, and stores a 1-bit edge map in internal RAM. It then drives the 12-bit rgb bus from the VGA sync counters (x, y, video_on), upscaling the map 4x to fill 640x480.

## Interface
- IMG_W, 160, image width in pixels
- IMG_H, 120, image height in pixels
- THRESH, 100, edge threshold; a pixel is an edge when |Gx|+|Gy| >= THRESH
- EDGE_RGB, 12'hFFF, colour for edge pixels
- BG_RGB, 12'h000, colour for non-edge pixels

- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins edge-map computation
- rom_addr  out  15  image ROM address, row*IMG_W+col
- rom_data  in  8  ROM data, valid one clk after rom_addr
- x  in  10  horizontal pixel count from vga_sync
- y  in  10  vertical pixel count from vga_sync
- video_on  in  1  active-display flag from vga_sync
- busy  out  1  computation in progress
- done  out  1  edge map valid (level, sticky)
- rgb  out  12  pixel colour to the VGA DAC

## Operation
- FSM states: IDLE, FETCH, LAST, CALC, WRITE. Scan order is row-major; pixel counters row 0..IMG_H-1, col 0..IMG_W-1.
- IDLE: start=1 -> clear done, set busy, row=col=0, enter WRITE (border pixel) or FETCH. start while busy is ignored.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1): no ROM reads; WRITE stores 0; 1 clk per pixel.
- Interior pixel: FETCH runs 9 clks, k=0..8, issuing addresses for the 3x3 window in order (r-1,c-1),(r-1,c),(r-1,c+1),(r,c-1)...(r+1,c+1). rom_data from step k is captured into window register p[k] on the next clk. LAST (1 clk) captures p[8]. CALC (1 clk) registers the magnitude. WRITE (1 clk) stores the edge bit. 12 clks per interior pixel.
- Arithmetic: Gx = (p2+2p5+p8)-(p0+2p3+p6), Gy = (p6+2p7+p8)-(p0+2p1+p2), each 11-bit signed (range +/-1020). Magnitude = |Gx|+|Gy| as 11-bit unsigned (max 2040), compared unsigned against THRESH. Address = row*160 computed as (row<<7)+(row<<5)+col, 15 bits.
- WRITE advances col; at col=IMG_W-1 it wraps col to 0 and increments row. WRITE of (IMG_H-1, IMG_W-1) -> IDLE, busy=0, done=1.
- Full frame: 18644 interior pixels * 12 + 556 border pixels * 1 = 224284 clks from the first post-start cycle to the done rise.
- Display: map address = (y>>2)*160 + (x>>2). rgb = EDGE_RGB if video_on && done && bit=1; BG_RGB if video_on && done && bit=0; 12'h000 if video_on=0 or done=0.
- Reset: FSM -> IDLE; busy=0, done=0, rom_addr=0, rgb=0, counters=0. Edge RAM contents are not cleared; done=0 masks them. Reset mid-frame abandons the computation, and a new start is required.

## Timing
- busy rises on the clk edge that samples start=1 in IDLE. busy falls and done rises on the same edge, which ends the final WRITE.
- rom_addr is registered and changes on every FETCH clk. It holds its last value outside FETCH.
- rgb is registered. It reflects the x, y, video_on values sampled two clk edges earlier (edge-RAM read, then rgb register). x and y hold for 4 clks per pixel, so each displayed pixel is stable for at least 2 clks.
- Display reads and engine writes are on separate RAM ports. A read during computation is harmless because done=0 masks the output.

## Test plan
- Uniform image, all pixels 0x80: start -> busy for exactly 224284 clks, done=1, every edge bit 0, rgb=000 across the whole active area.
- Vertical step, cols<80 = 0 and cols>=80 = 255: cols 79 and 80 have Gx=1020 and are edges for rows 1..118; all other pixels are 0. rgb=FFF for x 316..323, y 4..475; 000 elsewhere.
- Threshold boundary with THRESH=100, step of height v at col 80: v=25 gives mag 100 at cols 79/80, so these are edges. v=24 gives mag 96, so there are no edges.
- Border pixels, random image with rows 0/119 and cols 0/159 = 255 next to a 0 interior: border bits all 0. rom_addr is never driven for a window centred on a border pixel.
- Reset asserted 1000 clks into computation: busy=0, done=0, rgb=0 immediately. A subsequent start completes in 224284 clks with the correct map. A second start pulse during busy has no effect on timing.
- video_on=0 with done=1 and an edge at the addressed pixel -> rgb=000. Switching video_on to 1 gives rgb=FFF two clks later.
